regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared parameters, requester indices and helpers for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam int PW   = $clog2(NREQ);

  typedef enum logic [PW-1:0] {
    REQ_ALU = PW'(0),
    REQ_MEM = PW'(1),
    REQ_MDU = PW'(2)
  } req_id_e;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // Round-robin successor of a requester index (wraps at NREQ, not at 2**PW).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// NREQ-way round-robin arbiter: search starts just after the last granted requester.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  logic [PW-1:0]   last;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] grant_raw;
  logic            found;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_raw = '0;
    found     = 1'b0;
    winner    = last;
    idx       = last;
    for (int k = 0; k < NREQ; k++) begin
      idx = next_idx(idx);
      if (!found && valid[idx]) begin
        grant_raw[idx] = 1'b1;
        winner         = idx;
        found          = 1'b1;
      end
    end
  end

  // Grant is suppressed while reset is held so no requester sees a handshake.
  assign grant = rst_n ? grant_raw : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PW'(NREQ - 1);
    end else if (advance) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among ALU/MEM/MDU writeback and tracks busy registers.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [AW*NREQ-1:0] req_wn,
  input  logic [DW*NREQ-1:0] req_wd,
  output logic [NREQ-1:0]    req_ready,
  output logic               RegWrite,
  output logic [AW-1:0]      WN,
  output logic [DW-1:0]      WD,
  input  logic               claim_valid,
  input  logic [AW-1:0]      claim_wn,
  input  logic               flush,
  input  logic [AW-1:0]      RN1,
  input  logic [AW-1:0]      RN2,
  output logic [NREG-1:0]    busy,
  output logic               busy_rn1,
  output logic               busy_rn2
);

  logic            transfer;
  logic [AW-1:0]   sel_wn;
  logic [DW-1:0]   sel_wd;
  logic [NREG-1:0] busy_nxt;

  assign transfer = |(req_valid & req_ready);

  rr_arbiter u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (transfer),
    .grant   (req_ready)
  );

  // Grant is one-hot, so an AND-OR mux selects the winning write.
  always_comb begin
    sel_wn = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_wn = sel_wn | req_wn[AW*i +: AW];
        sel_wd = sel_wd | req_wd[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      WN       <= '0;
      WD       <= '0;
    end else if (transfer) begin
      RegWrite <= (sel_wn != REG_ZERO);
      WN       <= sel_wn;
      WD       <= sel_wd;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // Order matters: a claim overrides a same-edge clear, and flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (RegWrite) begin
      busy_nxt[WN] = 1'b0;
    end
    if (claim_valid && (claim_wn != REG_ZERO)) begin
      busy_nxt[claim_wn] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  // NOTE: the 32-bit scoreboard is small flop state, not a RAM, so it is cleared by reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_rn1 = busy[RN1];
  assign busy_rn2 = busy[RN2];

endmodule
